// File: rtl/wb_sram16.sv
// wb_sram16: Wishbone classic slave splitting each 32-bit access into two big-endian 16-bit async SRAM halves
module wb_sram16 #(
  parameter int adr_width = 18,
  parameter int latency = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [3:0]           wb_sel_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] sram_adr,
  inout  wire  [15:0]          sram_dat,
  output logic [1:0]           sram_be_n,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);
  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR0_REC, WR1, WR1_REC, ACK} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [adr_width-2:0] adr_q, adr_c;
  logic [3:0] sel_q, sel_c;
  logic [31:0] dat_q, dat_c;
  logic [15:0] dat_out;
  logic dat_oe, start, last, act, rd, wr, h1, unused;
  assign start = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign last = cnt == 4'(latency - 1);
  // In IDLE the bus inputs feed the output registers directly, since the latches load on the same edge
  assign adr_c = state == IDLE ? wb_adr_i[adr_width:2] : adr_q;
  assign sel_c = state == IDLE ? wb_sel_i : sel_q;
  assign dat_c = state == IDLE ? wb_dat_i : dat_q;
  assign act = nxt != IDLE && nxt != ACK;
  assign rd = nxt == RD0 || nxt == RD1;
  assign wr = act && !rd;
  assign h1 = nxt == RD1 || nxt == WR1 || nxt == WR1_REC;
  assign unused = ^{wb_adr_i[31:adr_width+1], wb_adr_i[1:0]};
  assign sram_dat = dat_oe ? dat_out : 'z;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = !wb_we_i ? RD0 : |wb_sel_i[3:2] ? WR0 : |wb_sel_i[1:0] ? WR1 : ACK;
      RD0:     if (last) nxt = RD1;
      RD1:     if (last) nxt = ACK;
      WR0:     if (last) nxt = WR0_REC;
      WR0_REC: nxt = |sel_q[1:0] ? WR1 : ACK;
      WR1:     if (last) nxt = WR1_REC;
      WR1_REC: nxt = ACK;
      default: nxt = IDLE;
    endcase
  end
  // SRAM controls are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      adr_q <= '0;
      sel_q <= '0;
      dat_q <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      sram_adr <= '0;
      sram_be_n <= 2'b11;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      dat_oe <= 1'b0;
      dat_out <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt == state ? cnt + 4'd1 : '0;
      if (state == IDLE) {adr_q, sel_q, dat_q} <= {wb_adr_i[adr_width:2], wb_sel_i, wb_dat_i};
      if (state == RD0 && last) wb_dat_o[31:16] <= sram_dat;
      if (state == RD1 && last) wb_dat_o[15:0] <= sram_dat;
      wb_ack_o <= nxt == ACK;
      sram_ce_n <= !act;
      sram_oe_n <= !rd;
      sram_we_n <= !(nxt == WR0 || nxt == WR1);
      dat_oe <= wr;
      if (act) sram_adr <= {adr_c, h1};
      sram_be_n <= !wr ? (rd ? 2'b00 : 2'b11) : h1 ? ~sel_c[1:0] : ~sel_c[3:2];
      dat_out <= h1 ? dat_c[15:0] : dat_c[31:16];
    end
endmodule

// File: tb/tb_wb_sram16.sv
// tb_wb_sram16: three bridges (latency 1, 2, 4) each on its own async SRAM model, driven by directed vectors
module tb_wb_sram16;
  logic clk = 0, reset_n = 0, cyc = 0, we = 0;
  logic [2:0] stb = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0] sel = '0;
  logic [2:0] ack, ce_n, oe_n, we_n, dz;
  logic [31:0] rd [3];
  logic [17:0] sa [3];
  logic [1:0] be [3];
  int lat [3] = '{1, 2, 4};
  int n = 0, err = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = g == 0 ? 1 : g == 1 ? 2 : 4;
    wire [15:0] sd;
    logic [15:0] mem [0:1023] = '{default: 16'h0};
    logic pw = 0, bad = 0;
    logic [15:0] pd;
    logic [9:0] pa;
    logic [1:0] pb;
    wb_sram16 #(.adr_width(18), .latency(L)) dut (
      .clk(clk), .reset_n(reset_n), .wb_cyc_i(cyc), .wb_stb_i(stb[g]), .wb_we_i(we),
      .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(rd[g]), .wb_ack_o(ack[g]),
      .sram_adr(sa[g]), .sram_dat(sd), .sram_be_n(be[g]), .sram_ce_n(ce_n[g]),
      .sram_oe_n(oe_n[g]), .sram_we_n(we_n[g]));
    assign sd = (!ce_n[g] && !oe_n[g]) ? mem[sa[g][9:0]] : 16'hzzzz;
    assign dz[g] = sd === 16'hzzzz;
    // A write lands in the array only when WE rises while CE is still low, so an aborted pulse is lost
    always @(negedge clk) begin
      if (pw && !ce_n[g] && we_n[g]) begin
        if (!pb[1]) mem[pa][15:8] = pd[15:8];
        if (!pb[0]) mem[pa][7:0] = pd[7:0];
      end
      pw = !ce_n[g] && !we_n[g];
      if (pw) {pd, pa, pb} = {sd, sa[g][9:0], be[g]};
      if (!oe_n[g] && !we_n[g]) begin
        bad = 1;
        $display("FAIL oe_we_overlap inst %0d: oe_n=0 we_n=0, required never both low", g);
      end
      if (!dz[g] && oe_n[g] && ce_n[g]) begin
        bad = 1;
        $display("FAIL dat_drive inst %0d: sram_dat=%h with ce_n=1, required Z", g, sd);
      end
    end
  end

  typedef struct {
    logic w;
    logic [31:0] a;
    logic [3:0] s;
    logic [31:0] d;
    logic [31:0] e;
    logic [1:0] b;
  } vec_t;
  vec_t tv [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int ecyc(input int l, input logic w, input logic [3:0] s);
    return !w ? 1 + 2 * l : s == 0 ? 1 : (|s[3:2] && |s[1:0]) ? 3 + 2 * l : 2 + l;
  endfunction

  // Called in an IDLE cycle; returns in the IDLE cycle after the ack
  task automatic op(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, output logic [31:0] r, output logic [1:0] bl);
    int c, cel;
    cyc = 1; stb = 3'(1 << k); we = w; adr = a; sel = s; wdat = d;
    c = 0; cel = 0; bl = 2'b11;
    do begin
      @(posedge clk); #1; c++;
      if (!ce_n[k]) begin cel++; bl = be[k]; end
    end while (!ack[k] && c < 60);
    cyc = 0; stb = '0; we = 0;
    r = rd[k];
    chk($sformatf("ack_cycle k%0d a%h", k, a), 32'(c), 32'(ecyc(lat[k], w, s)));
    chk($sformatf("ce_cycles k%0d a%h", k, a), 32'(cel), 32'(ecyc(lat[k], w, s) - 1));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r, d;
    logic [31:0] sb [16];
    logic [1:0] bl;
    logic [3:0] s;
    int c;
    tv[0]  = '{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 32'h0,        2'b00};
    tv[1]  = '{1'b0, 32'h10,       4'hF, 32'h0,        32'hDEADBEEF, 2'b00};
    tv[2]  = '{1'b0, 32'h80000013, 4'hF, 32'h0,        32'hDEADBEEF, 2'b00};
    tv[3]  = '{1'b1, 32'h20,       4'hF, 32'h11223344, 32'hDEADBEEF, 2'b00};
    tv[4]  = '{1'b1, 32'h20,       4'h4, 32'hAABBCCDD, 32'hDEADBEEF, 2'b10};
    tv[5]  = '{1'b0, 32'h20,       4'hF, 32'h0,        32'h11BB3344, 2'b00};
    tv[6]  = '{1'b1, 32'h20,       4'h0, 32'h55555555, 32'h11BB3344, 2'b11};
    tv[7]  = '{1'b0, 32'h20,       4'hF, 32'h0,        32'h11BB3344, 2'b00};
    tv[8]  = '{1'b1, 32'h24,       4'hF, 32'h01020304, 32'h11BB3344, 2'b00};
    tv[9]  = '{1'b1, 32'h24,       4'h3, 32'hCAFEF00D, 32'h11BB3344, 2'b00};
    tv[10] = '{1'b0, 32'h24,       4'hF, 32'h0,        32'h0102F00D, 2'b00};
    tv[11] = '{1'b1, 32'h24,       4'h9, 32'hA1B2C3D4, 32'h0102F00D, 2'b10};
    tv[12] = '{1'b0, 32'h24,       4'hF, 32'h0,        32'hA102F0D4, 2'b00};
    tv[13] = '{1'b0, 32'h10,       4'hF, 32'h0,        32'hDEADBEEF, 2'b00};
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_ctl k%0d {ack,ce,oe,we,be,z}", k),
          32'({ack[k], ce_n[k], oe_n[k], we_n[k], be[k], dz[k]}), 32'b0111111);
      chk($sformatf("reset_dat k%0d", k), rd[k], 32'h0);
      chk($sformatf("reset_adr k%0d", k), 32'(sa[k]), 32'h0);
    end
    @(negedge clk) reset_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_stb {ack,ce_n}", 32'({ack, ce_n}), 32'b000111);
    for (int i = 0; i < 14; i++) begin
      op(1, tv[i].w, tv[i].a, tv[i].s, tv[i].d, r, bl);
      chk($sformatf("vec%0d dat_o", i), r, tv[i].e);
      chk($sformatf("vec%0d be_n", i), 32'(bl), 32'(tv[i].b));
    end
    chk("mem[8]", 32'(u[1].mem[8]), 32'hDEAD);
    chk("mem[9]", 32'(u[1].mem[9]), 32'hBEEF);
    // Master abandons a write after one cycle: the access must still finish and ack
    cyc = 1; stb = 3'b010; we = 1; adr = 32'h28; sel = 4'hF; wdat = 32'h0BADF00D;
    @(posedge clk); #1;
    c = 1; cyc = 0; stb = '0; we = 0;
    while (!ack[1] && c < 60) begin @(posedge clk); #1; c++; end
    chk("drop_ack_cycle", 32'(c), 32'(ecyc(2, 1'b1, 4'hF)));
    @(posedge clk); #1;
    op(1, 1'b0, 32'h28, 4'hF, 32'h0, r, bl);
    chk("drop_readback", r, 32'h0BADF00D);
    // Reset during the second write half loses that half only
    op(1, 1'b1, 32'h30, 4'hF, 32'h12345678, r, bl);
    cyc = 1; stb = 3'b010; we = 1; adr = 32'h30; sel = 4'hF; wdat = 32'h9ABCDEF0;
    repeat (4) @(posedge clk);
    #1;
    chk("wr1_{we_n,adr}", 32'({we_n[1], sa[1]}), 32'({1'b0, 18'h19}));
    #1 reset_n = 0;
    #1;
    chk("reset_mid_wr {we_n,ce_n,z,ack}", 32'({we_n[1], ce_n[1], dz[1], ack[1]}), 32'b1110);
    cyc = 0; stb = '0; we = 0;
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    op(1, 1'b0, 32'h30, 4'hF, 32'h0, r, bl);
    chk("reset_mid_wr readback", r, 32'h9ABC5678);
    for (int k = 0; k < 3; k += 2) begin
      for (int i = 0; i < 16; i++) begin
        sb[i] = $urandom;
        op(k, 1'b1, 32'h100 + 32'(4 * i), 4'hF, sb[i], r, bl);
        op(k, 1'b0, 32'h100 + 32'(4 * i), 4'hF, 32'h0, r, bl);
        chk($sformatf("rand k%0d w%0d", k, i), r, sb[i]);
      end
      for (int i = 0; i < 16; i++) begin
        s = 4'($urandom_range(0, 15));
        d = $urandom;
        op(k, 1'b1, 32'h100 + 32'(4 * i), s, d, r, bl);
        for (int b = 0; b < 4; b++) if (s[b]) sb[i][8*b +: 8] = d[8*b +: 8];
        op(k, 1'b0, 32'h100 + 32'(4 * i), 4'hF, 32'h0, r, bl);
        chk($sformatf("rand_sel k%0d w%0d sel%h", k, i, s), r, sb[i]);
      end
    end
    chk("bus_monitor clean", 32'({u[0].bad, u[1].bad, u[2].bad}), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule

// File: doc/wb_sram16.md
Name: wb_sram16

Overview:
- 32-bit Wishbone classic slave that bridges the LM32 data/instruction bus to the board's external 16-bit asynchronous SRAM (DE1, 256K x 16).
- Sits directly upstream of the sram16 device: the system arbiter feeds it, and it drives sram_addr/sram_dq/sram_ub_n/sram_lb_n/sram_ce_n/sram_oe_n/sram_we_n.
- Each 32-bit access is split into two 16-bit SRAM half accesses, big-endian, with a programmable number of wait cycles.

Parameters:
- adr_width, 18: SRAM address width in 16-bit half-words.
- latency, 2: SRAM access cycles per half (strobe width for OE/WE). Legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address. Bits [adr_width:2] are used; all other bits are ignored.
- wb_sel_i  in  4  byte selects. sel[3] selects data bits 31:24.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- sram_adr  out  adr_width  SRAM half-word address.
- sram_dat  inout  16  SRAM data bus.
- sram_be_n  out  2  byte enables, active-low. [1] is upper byte (ub_n), [0] is lower byte (lb_n).
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Reset (async, reset_n=0), all outputs forced:
  - wb_ack_o=0, wb_dat_o=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=2'b11, sram_adr=0.
  - sram_dat=Z.
  - FSM in IDLE, wait counter 0.
- Address mapping:
  - Half 0 (data bits 31:16) → sram_adr = {wb_adr_i[adr_width:2], 1'b0}.
  - Half 1 (data bits 15:0) → sram_adr = {wb_adr_i[adr_width:2], 1'b1}.
- Byte enables:
  - Writes: half 0 uses be_n = ~sel[3:2]; half 1 uses be_n = ~sel[1:0].
  - Reads: be_n = 2'b00 on both halves.
- All SRAM outputs are registered. sram_dat is driven only in write states, from a registered copy of wb_dat_i.
- FSM states: IDLE, RD0, RD1, WR0, WR0_REC, WR1, WR1_REC, ACK.
- IDLE:
  - Start condition is wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - On start, latch address, sel and data.
  - Read → RD0.
  - Write with sel[3:2]!=0 → WR0.
  - Write with sel[3:2]==0 and sel[1:0]!=0 → WR1.
  - Write with sel==0 → ACK directly; no SRAM activity.
- RD0 / RD1:
  - ce_n=0, oe_n=0, for `latency` cycles each.
  - sram_dat is sampled on the last cycle of the state into wb_dat_o[31:16] (RD0) or wb_dat_o[15:0] (RD1).
  - RD0 → RD1; RD1 → ACK.
- WR0 / WR1:
  - ce_n=0, we_n=0, data driven, for `latency` cycles.
  - WRx → WRx_REC.
- WR0_REC / WR1_REC:
  - One cycle with we_n=1; ce_n, address and data held (hold time).
  - WR0_REC → WR1 if sel[1:0]!=0, else → ACK.
  - WR1_REC → ACK.
- ACK:
  - wb_ack_o=1 for exactly one cycle; ce_n=1, oe_n=1, we_n=1; dat Z.
  - ACK → IDLE unconditionally.
- Latency, measured from the IDLE cycle in which start is seen (cycle 0) to the ack cycle:
  - Read: ack at cycle 1+2*latency (latency=2 → cycle 5).
  - Full write: ack at cycle 1+2*(latency+1) (→ 7).
  - Single-half write: ack at cycle 1+(latency+1) (→ 4).
  - sel==0 write: ack at cycle 1.
- Bus contention: oe_n and we_n are never low simultaneously. oe_n=1 for at least one cycle before sram_dat leaves Z.
- wb_dat_o holds its last read value until the next read completes. It is not cleared by writes.
- Master drops wb_cyc_i/wb_stb_i mid-transfer: the current access still completes to ACK (SRAM state kept consistent). Ack is issued, and the arbiter ignores it.
- Back-to-back: a new start is accepted in the IDLE cycle immediately after ACK. One idle cycle is therefore guaranteed between accesses, with ce_n=1.
- reset_n asserted mid-access: immediate return to reset values, including sram_we_n=1 and dat Z. The partial write is lost.

Test Plan:
- Reset check: hold reset_n=0 and toggle clk → ack=0, ce_n=oe_n=we_n=1, be_n=11, sram_dat=Z; release → FSM stays in IDLE with no stb.
- Full write then read: write 0xDEADBEEF, sel=1111, adr=0x00000010 → SRAM half-addr 8 =0xDEAD, 9 =0xBEEF, ack at cycle 7. Read same address → wb_dat_o=0xDEADBEEF, ack at cycle 5.
- Byte write:
  - Preload 0x11223344 at 0x20, write 0xAABBCCDD with sel=0100 → only WR0 performed (ack cycle 4), be_n=10.
  - Readback=0x11BB3344.
- sel=0000 write → ack at cycle 1; ce_n never asserted; memory unchanged.
- Back-to-back mixed sequence:
  - Write, read, write, read of 16 random words, with latency parameter also set to 1 and 4.
  - Readback matches a scoreboard; ack timing matches the formulas.
  - Assertion checks: oe_n&we_n never both 0, and sram_dat driven only while we-phase states are active.
- Reset mid-write: assert reset_n=0 during WR1 → we_n=1 and dat=Z within the same timestep. After release the next read returns the completed half 0 and the old half 1.
